// File: rtl/pso_pkg.sv
// Shared definitions for the PSO MPPT control slice.
// Holds the evaluation scheduler state type, ADC/power widths and the default
// duty and particle-index widths shared with the PSO core and PWM generator.
package pso_pkg;

    localparam int unsigned ADC_W      = 12;
    localparam int unsigned PWR_W      = 24;
    localparam int unsigned DUTY_W_DEF = 10;
    localparam int unsigned PID_W_DEF  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StCalc,
        StReport
    } eval_state_e;

endpackage

// File: rtl/pso_eval_sched_if.sv
// Bus between the PSO core side (master) and the evaluation scheduler (slave).
// Carries control (ena, best_clear), the candidate duty handshake, the ADC words,
// the result handshake, the applied duty, global-best outputs and busy.
interface pso_eval_sched_if
    import pso_pkg::*;
#(
    parameter int unsigned DUTY_W = DUTY_W_DEF,
    parameter int unsigned PID_W  = PID_W_DEF
);
    logic              ena;
    logic              best_clear;
    logic              duty_valid;
    logic              duty_ready;
    logic [DUTY_W-1:0] duty_in;
    logic [PID_W-1:0]  pid_in;
    logic [ADC_W-1:0]  ad1_in;
    logic [ADC_W-1:0]  ad2_in;
    logic [DUTY_W-1:0] duty_out;
    logic              res_valid;
    logic              res_ready;
    logic [PID_W-1:0]  res_pid;
    logic [PWR_W-1:0]  res_power;
    logic [DUTY_W-1:0] best_duty;
    logic [PWR_W-1:0]  best_power;
    logic              best_valid;
    logic              busy;

    modport master (
        output ena, best_clear, duty_valid, duty_in, pid_in, ad1_in, ad2_in, res_ready,
        input  duty_ready, duty_out, res_valid, res_pid, res_power,
               best_duty, best_power, best_valid, busy
    );

    modport slave (
        input  ena, best_clear, duty_valid, duty_in, pid_in, ad1_in, ad2_in, res_ready,
        output duty_ready, duty_out, res_valid, res_pid, res_power,
               best_duty, best_power, best_valid, busy
    );
endinterface

// File: rtl/pso_avg_acc.sv
// Dual ADC accumulator with sample prescaler and sample counter.
// Ports: clk, reset (async, active-high); start_i/abort_i clear all state;
// run_i advances the prescaler; ad1_i/ad2_i ADC words; done_o pulses on the
// edge that takes the last sample; acc_v_o/acc_i_o running sums.
module pso_avg_acc
    import pso_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 50,
    parameter int unsigned NAVG_LOG2  = 3,
    localparam int unsigned ACC_W     = ADC_W + NAVG_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             run_i,
    input  logic [ADC_W-1:0] ad1_i,
    input  logic [ADC_W-1:0] ad2_i,
    output logic             done_o,
    output logic [ACC_W-1:0] acc_v_o,
    output logic [ACC_W-1:0] acc_i_o
);
    localparam int unsigned PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W = NAVG_LOG2 + 1;
    localparam int unsigned NAVG  = 1 << NAVG_LOG2;

    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_v_q, acc_i_q;
    logic             tick;

    // First tick lands on the SAMPLE_DIV-th clock of run.
    assign tick    = run_i && (pre_q == PRE_W'(SAMPLE_DIV - 1));
    assign done_o  = tick && (cnt_q == CNT_W'(NAVG - 1));
    assign acc_v_o = acc_v_q;
    assign acc_i_o = acc_i_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            acc_v_q <= '0;
            acc_i_q <= '0;
        end else if (start_i || abort_i) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            acc_v_q <= '0;
            acc_i_q <= '0;
        end else if (run_i) begin
            if (tick) begin
                pre_q   <= '0;
                cnt_q   <= cnt_q + 1'b1;
                acc_v_q <= acc_v_q + ACC_W'(ad1_i);
                acc_i_q <= acc_i_q + ACC_W'(ad2_i);
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pso_eval_sched.sv
// PSO fitness evaluation scheduler: accepts a candidate duty, applies it,
// waits SETTLE_CYC clocks, averages NAVG voltage/current samples, returns
// avg_v*avg_i as fitness and tracks the global best duty/power.
// Ports: clk, reset (async, active-high); bus (slave modport) carries all
// handshake, ADC, result, best and status signals.
module pso_eval_sched
    import pso_pkg::*;
#(
    parameter int unsigned DUTY_W     = DUTY_W_DEF,
    parameter int unsigned PID_W      = PID_W_DEF,
    parameter int unsigned DUTY_INIT  = 512,
    parameter int unsigned SETTLE_CYC = 2000,
    parameter int unsigned SAMPLE_DIV = 50,
    parameter int unsigned NAVG_LOG2  = 3
) (
    input  logic                clk,
    input  logic                reset,
    pso_eval_sched_if.slave     bus
);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned ACC_W = ADC_W + NAVG_LOG2;

    eval_state_e       state_q;
    logic [SET_W-1:0]  settle_q;
    logic [DUTY_W-1:0] duty_out_q, best_duty_q;
    logic [PID_W-1:0]  res_pid_q;
    logic [PWR_W-1:0]  res_power_q, best_power_q;
    logic              best_valid_q;

    logic              accept, abort, run, acc_done;
    logic [ACC_W-1:0]  acc_v, acc_i;
    logic [ADC_W-1:0]  avg_v, avg_i;
    logic [PWR_W-1:0]  power;

    assign accept = (state_q == StIdle) && bus.ena && bus.duty_valid;
    assign abort  = ((state_q == StSettle) || (state_q == StSample)) && !bus.ena;
    assign run    = (state_q == StSample) && bus.ena;

    pso_avg_acc #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .NAVG_LOG2  (NAVG_LOG2)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept),
        .abort_i (abort),
        .run_i   (run),
        .ad1_i   (bus.ad1_in),
        .ad2_i   (bus.ad2_in),
        .done_o  (acc_done),
        .acc_v_o (acc_v),
        .acc_i_o (acc_i)
    );

    // Dropping the low NAVG_LOG2 bits is the divide-by-NAVG average.
    assign avg_v = acc_v[ACC_W-1:NAVG_LOG2];
    assign avg_i = acc_i[ACC_W-1:NAVG_LOG2];
    assign power = PWR_W'(avg_v) * PWR_W'(avg_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            settle_q     <= '0;
            duty_out_q   <= DUTY_W'(DUTY_INIT);
            res_pid_q    <= '0;
            res_power_q  <= '0;
            best_duty_q  <= '0;
            best_power_q <= '0;
            best_valid_q <= 1'b0;
        end else begin
            if (bus.best_clear) begin
                best_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        duty_out_q <= bus.duty_in;
                        res_pid_q  <= bus.pid_in;
                        settle_q   <= '0;
                        state_q    <= StSettle;
                    end
                end
                StSettle: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                        settle_q <= '0;
                        state_q  <= StSample;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StSample: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (acc_done) begin
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    res_power_q <= power;
                    // A clear on this edge still lets the fresh result become best.
                    if (!best_valid_q || bus.best_clear || (power > best_power_q)) begin
                        best_duty_q  <= duty_out_q;
                        best_power_q <= power;
                        best_valid_q <= 1'b1;
                    end
                    state_q <= StReport;
                end
                StReport: begin
                    if (bus.res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.duty_ready = (state_q == StIdle) && bus.ena;
    assign bus.res_valid  = (state_q == StReport);
    assign bus.busy       = (state_q != StIdle);
    assign bus.duty_out   = duty_out_q;
    assign bus.res_pid    = res_pid_q;
    assign bus.res_power  = res_power_q;
    assign bus.best_duty  = best_duty_q;
    assign bus.best_power = best_power_q;
    assign bus.best_valid = best_valid_q;
endmodule

// File: doc/pso_eval_sched.md
Name: pso_eval_sched

Overview:
- Evaluation scheduler for the PSO MPPT loop.
- Accepts one candidate duty per particle from the PSO core and applies it to the PWM generator.
- Waits for the converter to settle, then averages the voltage (ad1_in) and current (ad2_in) ADC words and computes power.
- Returns the fitness to the PSO core and tracks the global best duty/power.
- Sits between the PSO update core, the PWM generator and the ADC interface inside control.

Parameters:
- DUTY_W, 10, duty word width fed to the PWM generator.
- PID_W, 3, particle index width.
- DUTY_INIT, 512, duty_out value after reset.
- SETTLE_CYC, 2000, clocks to wait after applying a duty before sampling (>=1).
- SAMPLE_DIV, 50, clocks between ADC samples (>=1).
- NAVG_LOG2, 3, log2 of samples averaged per evaluation (NAVG = 2^NAVG_LOG2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  scheduler enable
- best_clear  in  1  one-cycle pulse: invalidate global best
- duty_valid  in  1  candidate duty offered by PSO core
- duty_ready  out  1  scheduler can accept candidate
- duty_in  in  DUTY_W  candidate duty
- pid_in  in  PID_W  particle index of candidate
- ad1_in  in  12  PV voltage ADC word, unsigned
- ad2_in  in  12  PV current ADC word, unsigned
- duty_out  out  DUTY_W  duty applied to PWM generator (registered)
- res_valid  out  1  fitness result available
- res_ready  in  1  PSO core consumes result
- res_pid  out  PID_W  particle index of result
- res_power  out  24  averaged V × averaged I
- best_duty  out  DUTY_W  duty of best power since reset/clear
- best_power  out  24  best power since reset/clear
- best_valid  out  1  best_* hold a real measurement
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - State IDLE; duty_out = DUTY_INIT.
  - duty_ready = 0, res_valid = 0, busy = 0.
  - res_pid, res_power, best_duty, best_power, best_valid, accumulators and counters all 0.
- FSM states: IDLE, SETTLE, SAMPLE, CALC, REPORT.
- IDLE:
  - duty_ready = ena.
  - On an edge with duty_valid && duty_ready: duty_out <= duty_in, res_pid <= pid_in, accumulators and counters cleared, go to SETTLE.
- SETTLE: counts SETTLE_CYC clocks, then goes to SAMPLE.
- SAMPLE:
  - Prescaler fires every SAMPLE_DIV clocks; the first sample is taken on the SAMPLE_DIV-th clock in SAMPLE.
  - Each tick: acc_v += ad1_in, acc_i += ad2_in. Accumulators are (12+NAVG_LOG2) bits wide and cannot overflow.
  - After the NAVG-th sample, go to CALC.
- CALC (1 clock):
  - avg_v = acc_v >> NAVG_LOG2 and avg_i = acc_i >> NAVG_LOG2, both truncated to 12 bits.
  - res_power <= avg_v × avg_i, an unsigned 24-bit full product.
  - Go to REPORT.
- Latency: res_valid rises exactly SETTLE_CYC + NAVG×SAMPLE_DIV + 1 clocks after the accept edge.
- REPORT:
  - res_valid = 1; res_pid and res_power are held stable until the edge with res_ready = 1, then go to IDLE.
  - duty_ready = 0 throughout REPORT, so back-to-back accepts are separated by at least 1 IDLE clock.
- Global best:
  - Updated on the CALC→REPORT edge if !best_valid or the new power > best_power (strict).
  - Update sets best_duty <= duty_out, best_power <= new power, best_valid <= 1.
  - Equal power keeps the older best.
- best_clear:
  - Clears best_valid; best_duty and best_power are held but meaningless.
  - If best_clear coincides with the CALC→REPORT edge, the new result becomes best (best_valid = 1).
- ena:
  - ena = 0 in SETTLE or SAMPLE aborts to IDLE at the next edge; the partial accumulation is discarded, duty_out is held, and no result is issued.
  - ena is ignored in CALC and REPORT; a started handshake always completes.
- duty_out changes only on an accept edge; it is never glitched by an abort.
- ADC inputs are treated as already synchronous to clk.
- reset mid-operation: all state returns to reset values immediately (asynchronous).

Decomposition:
- Shared package pso_pkg holds:
  - the state enum;
  - the ADC width constant ADC_W = 12;
  - the power width PWR_W = 24;
  - the duty/pid width defaults, shared with the PSO core and the PWM generator.
- One natural sub-module, pso_avg_acc: dual accumulator, sample prescaler and sample counter, with start/abort inputs and a done pulse.
- FSM, multiply and best tracking stay in pso_eval_sched.

Test Plan (SETTLE_CYC=20, SAMPLE_DIV=4, NAVG_LOG2=2, so L=37):
- Reset: hold reset, release → duty_out=512, duty_ready=0 while ena=0 and 1 when ena=1; all other outputs 0.
- Single evaluation: ena=1, offer duty 300/pid 2, ad1=1000, ad2=200 constant → res_valid exactly 37 clocks after accept; res_power=200000, res_pid=2; best_duty=300, best_valid=1.
- Averaging/truncation: ad1 sequence 1000,1001,1001,1001 with ad2=4 → avg_v=1000, res_power=4000.
- Best tracking and backpressure:
  - Evaluate powers 5000, 5000 (duty 100), 7000 (duty 200), 3000 → best_duty=200, best_power=7000.
  - Hold res_ready=0 for 10 clocks → res_* stable and duty_ready=0 throughout.
- Abort: drop ena 10 clocks into SAMPLE → IDLE next edge, no res_valid, duty_out retains the new duty; the next evaluation result is unaffected by old samples.
- best_clear pulsed on the CALC→REPORT edge with power 1000, below the existing best 7000 → best_power=1000, best_valid=1.
